decode_rx_drv: RTL and testbench
================================

# decode_rx_drv

Receive-side counterpart of the timing-board encode/scan serial link. Recovers 16-bit words from the forwarded serial clock and data lanes by oversampling them in the local clock domain. Decodes the four sync words (encode trigger, scan begin, scan test, scan end) into trigger pulses, scan-enable levels and counters. Sits on the PMT/acquisition board directly behind the link pins.

## Interface
- TCQ, 0.1: simulation clock-to-Q delay.
- DATA_WIDTH, 16: word width; must be a multiple of SERIAL_MODE.
- SERIAL_MODE, 1: data lanes (1/2/4/8).
- IDLE_CYCLES, 64: clk_i cycles of SPI_MCLK low that end or abort a word.
- clk_i  input  1  sole clock (≥4× SPI_MCLK frequency).
- rst_n_i  input  1  asynchronous, active-low reset.
- SPI_MCLK  input  1  forwarded serial clock; idles low; runs only during a word.
- SPI_MOSI  input  SERIAL_MODE  data lanes; valid at SPI_MCLK rising edge.
- rx_valid_o  output  1  one-cycle pulse; rx_data_o holds a new word.
- rx_data_o  output  DATA_WIDTH  last received word.
- track_trigger_o  output  1  one-cycle pulse per 0xECDE received while scanning.
- pmt_start_en_o  output  1  scan active level.
- pmt_start_test_en_o  output  1  scan active in test mode.
- encode_cnt_o  output  32  encode words received in the current scan.
- frame_err_o  output  1  one-cycle pulse: partial word aborted by idle timeout.
- unknown_word_o  output  1  one-cycle pulse: complete word not a known sync word.
- err_cnt_o  output  16  saturating count of frame_err_o + unknown_word_o events.

## Operation
- Input conditioning: SPI_MCLK and SPI_MOSI each pass through two synchronizer flops, plus one delay flop on MCLK. A rising edge is a synchronized 0→1 transition.
- Shifter: on each rising edge, shift {SPI_MOSI} into the LSB side of the word. Lane SERIAL_MODE-1 is the more significant bit. The word is sent MSB first.
- Bit counter counts edges 0..DATA_WIDTH/SERIAL_MODE-1.
- States: IDLE (counter 0), SHIFT (counter > 0), DONE (one cycle).
- IDLE→SHIFT: first edge.
- SHIFT→DONE: the final edge. rx_data_o is loaded and rx_valid_o=1 in the next cycle. Counter returns to 0. DONE→IDLE.
- Idle timer: counts clk_i cycles with synchronized MCLK low. Cleared by any edge.
- If the timer reaches IDLE_CYCLES in SHIFT: discard the partial word, pulse frame_err_o, return to IDLE. There is no effect in IDLE.
- Decode runs on the rx_valid_o cycle; its outputs register one cycle later.
  - 0x5A51: pmt_start_en_o=1, pmt_start_test_en_o=0, encode_cnt_o=0.
  - 0x5A53: pmt_start_en_o=1, pmt_start_test_en_o=1, encode_cnt_o=0.
  - 0x5A50: both enables 0. encode_cnt_o is held for readout.
  - 0xECDE with pmt_start_en_o=1: track_trigger_o pulse, encode_cnt_o+1 (wraps at 2^32).
  - 0xECDE with pmt_start_en_o=0: dropped silently. No trigger, no count, no error.
  - Any other value: unknown_word_o pulse.
- A begin word received while already scanning restarts the scan. The counter clears and the test flag is re-taken from the new word.
- An end word received while idle causes no change.
- err_cnt_o increments on each frame_err_o or unknown_word_o pulse and saturates at 0xFFFF. It clears only on reset.

## Timing
- Reset (async assert, sync release via clk_i) sets all outputs to 0. This covers rx_data_o, the counters, the enables and the pulses. Synchronizers, shifter, bit counter and idle timer also clear.
- Latency:
  - Last MCLK rising edge at the pin → rx_valid_o: 4 clk_i cycles (2 sync + 1 edge detect + 1 load).
  - rx_valid_o → decoded outputs: 1 cycle.
- Pulses are exactly one clk_i cycle wide. Back-to-back words with zero gap are accepted. Minimum word spacing is DATA_WIDTH/SERIAL_MODE edges.
- No backpressure: rx_valid_o is not acknowledged, and a new word overwrites rx_data_o.
- Reset asserted mid-word discards the word. The first edge after release starts a new word.

## Test plan
- Reset: hold rst_n_i=0 while MCLK toggles → all outputs 0. Release → first full word decodes correctly.
- SERIAL_MODE=1: send 0x5A51, then three 0xECDE, then 0x5A50.
  - pmt_start_en_o rises 1 cycle after the first rx_valid_o.
  - Three track_trigger_o pulses.
  - encode_cnt_o=3 after the end word; the enable falls.
- SERIAL_MODE=4: send 0x5A53 → rx_data_o=0x5A53 and pmt_start_test_en_o=1. Then send 0xECDE, 0x5A51 → encode_cnt_o goes 1 then 0, and the test enable falls.
- Send 0xECDE while idle → no trigger, encode_cnt_o unchanged, err_cnt_o unchanged.
- Send 7 edges then hold MCLK low for IDLE_CYCLES → frame_err_o pulse and err_cnt_o=1. A following clean 0x5A51 decodes correctly.
- Send 0x1234 → unknown_word_o pulse and err_cnt_o+1. Force err_cnt_o to 0xFFFF → it stays 0xFFFF on the next error.

Source files
------------

// File: rtl/decode_rx_drv.sv
// decode_rx_drv: oversampling receiver for the encode/scan serial link.
// Recovers DATA_WIDTH-bit words from the forwarded SPI_MCLK/SPI_MOSI lanes
// in the clk_i domain. Decodes the scan/encode sync words into trigger
// pulses, scan-enable levels and counters.
module decode_rx_drv #(
    parameter int DATA_WIDTH  = 16,
    parameter int SERIAL_MODE = 1,
    parameter int IDLE_CYCLES = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   SPI_MCLK,
    input  logic [SERIAL_MODE-1:0] SPI_MOSI,
    output logic                   rx_valid_o,
    output logic [DATA_WIDTH-1:0]  rx_data_o,
    output logic                   track_trigger_o,
    output logic                   pmt_start_en_o,
    output logic                   pmt_start_test_en_o,
    output logic [31:0]            encode_cnt_o,
    output logic                   frame_err_o,
    output logic                   unknown_word_o,
    output logic [15:0]            err_cnt_o
);

    localparam int BEATS = DATA_WIDTH / SERIAL_MODE;
    localparam int CW    = (BEATS > 2) ? $clog2(BEATS) : 1;
    localparam int TW    = $clog2(IDLE_CYCLES + 1);

    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [TW-1:0] T_MAX     = TW'(IDLE_CYCLES);

    localparam logic [DATA_WIDTH-1:0] W_BEGIN = DATA_WIDTH'(16'h5A51);
    localparam logic [DATA_WIDTH-1:0] W_TEST  = DATA_WIDTH'(16'h5A53);
    localparam logic [DATA_WIDTH-1:0] W_END   = DATA_WIDTH'(16'h5A50);
    localparam logic [DATA_WIDTH-1:0] W_ENC   = DATA_WIDTH'(16'hECDE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clk_i edge
    // ------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst_n;

    // Two-flop reset release synchronizer
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0]             mclk_sync;
    logic                   mclk_d;
    logic [SERIAL_MODE-1:0] mosi_s1, mosi_s2;
    logic                   rise;

    // Double-flop synchronizers, plus a delay flop on MCLK for edge detect
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            mclk_sync <= '0;
            mclk_d    <= 1'b0;
            mosi_s1   <= '0;
            mosi_s2   <= '0;
        end else begin
            mclk_sync <= {mclk_sync[0], SPI_MCLK};
            mclk_d    <= mclk_sync[1];
            mosi_s1   <= SPI_MOSI;
            mosi_s2   <= mosi_s1;
        end
    end

    // Data travels through the same two-flop depth as MCLK, so mosi_s2 is
    // aligned with the edge that rise flags
    assign rise = mclk_sync[1] & ~mclk_d;

    // ------------------------------------------------------------------
    // Idle timer
    // ------------------------------------------------------------------
    logic [TW-1:0] timer_q;

    // Counts MCLK-low cycles. Saturates so a long idle never wraps back
    // below the threshold.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)                               timer_q <= '0;
        else if (rise)                            timer_q <= '0;
        else if (!mclk_sync[1] && timer_q != T_MAX) timer_q <= timer_q + TW'(1);
    end

    // ------------------------------------------------------------------
    // Deserializer FSM
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d, shifted;
    logic                  load, frame_err_d;

    // MSB-first: older beats move toward the MSB; lane SERIAL_MODE-1 is the
    // more significant bit within a beat
    assign shifted = {shreg_q[DATA_WIDTH-SERIAL_MODE-1:0], mosi_s2};

    // State, beat counter and shifter registers
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    // Next state: first edge opens a word, last edge closes it, idle
    // timeout mid-word throws the partial word away
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        load        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    shreg_d = shifted;
                    cnt_d   = CW'(1);
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (rise) begin
                    shreg_d = shifted;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (timer_q == T_MAX) begin
                    frame_err_d = 1'b1;
                    cnt_d       = '0;
                    shreg_d     = '0;
                    state_d     = S_IDLE;
                end
            end
            S_DONE: begin
                // An edge cannot arrive here: the synchronized MCLK was
                // high on the previous cycle
                load    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Word output and decode
    // ------------------------------------------------------------------
    logic                  rx_valid_q, frame_err_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  is_begin, is_test, is_end, is_enc, unknown_d;
    logic                  trig_q, unknown_q, en_q, test_q;
    logic [31:0]           enc_cnt_q;
    logic [15:0]           err_cnt_q;
    logic [16:0]           err_sum;

    // Completed word register and its valid / frame-error pulses
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= load;
            frame_err_q <= frame_err_d;
            if (load) rx_data_q <= shreg_q;
        end
    end

    assign is_begin  = (rx_data_q == W_BEGIN);
    assign is_test   = (rx_data_q == W_TEST);
    assign is_end    = (rx_data_q == W_END);
    assign is_enc    = (rx_data_q == W_ENC);
    assign unknown_d = rx_valid_q & ~(is_begin | is_test | is_end | is_enc);

    // Scan state and encode counter, updated the cycle after rx_valid
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            trig_q    <= 1'b0;
            unknown_q <= 1'b0;
            en_q      <= 1'b0;
            test_q    <= 1'b0;
            enc_cnt_q <= '0;
        end else begin
            trig_q    <= 1'b0;
            unknown_q <= unknown_d;
            if (rx_valid_q) begin
                if (is_begin || is_test) begin
                    // Begin while scanning restarts the scan
                    en_q      <= 1'b1;
                    test_q    <= is_test;
                    enc_cnt_q <= '0;
                end else if (is_end) begin
                    // Counter is left alone for readout after the scan
                    en_q   <= 1'b0;
                    test_q <= 1'b0;
                end else if (is_enc && en_q) begin
                    trig_q    <= 1'b1;
                    enc_cnt_q <= enc_cnt_q + 32'd1;
                end
            end
        end
    end

    // Both error sources may in principle coincide, so add both and clamp
    assign err_sum = {1'b0, err_cnt_q} + 17'(frame_err_d) + 17'(unknown_d);

    // Saturating error counter, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)                        err_cnt_q <= '0;
        else if (frame_err_d || unknown_d) err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    assign rx_valid_o          = rx_valid_q;
    assign rx_data_o           = rx_data_q;
    assign track_trigger_o     = trig_q;
    assign pmt_start_en_o      = en_q;
    assign pmt_start_test_en_o = test_q;
    assign encode_cnt_o        = enc_cnt_q;
    assign frame_err_o         = frame_err_q;
    assign unknown_word_o      = unknown_q;
    assign err_cnt_o           = err_cnt_q;

endmodule

// File: tb/tb_decode_rx_drv.sv
// Bench for decode_rx_drv: one single-lane and one four-lane instance,
// driven with directed words and compared against hand-computed results.
module tb_decode_rx_drv;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    // Single-lane instance
    logic        mclk_a;
    logic [0:0]  mosi_a;
    logic        vld_a, trig_a, en_a, test_a, ferr_a, unk_a;
    logic [15:0] data_a, err_a;
    logic [31:0] cnt_a;

    // Four-lane instance
    logic        mclk_b;
    logic [3:0]  mosi_b;
    logic        vld_b, trig_b, en_b, test_b, ferr_b, unk_b;
    logic [15:0] data_b, err_b;
    logic [31:0] cnt_b;

    decode_rx_drv #(.DATA_WIDTH(16), .SERIAL_MODE(1), .IDLE_CYCLES(64)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .SPI_MCLK(mclk_a), .SPI_MOSI(mosi_a),
        .rx_valid_o(vld_a), .rx_data_o(data_a), .track_trigger_o(trig_a),
        .pmt_start_en_o(en_a), .pmt_start_test_en_o(test_a), .encode_cnt_o(cnt_a),
        .frame_err_o(ferr_a), .unknown_word_o(unk_a), .err_cnt_o(err_a)
    );

    decode_rx_drv #(.DATA_WIDTH(16), .SERIAL_MODE(4), .IDLE_CYCLES(64)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .SPI_MCLK(mclk_b), .SPI_MOSI(mosi_b),
        .rx_valid_o(vld_b), .rx_data_o(data_b), .track_trigger_o(trig_b),
        .pmt_start_en_o(en_b), .pmt_start_test_en_o(test_b), .encode_cnt_o(cnt_b),
        .frame_err_o(ferr_b), .unknown_word_o(unk_b), .err_cnt_o(err_b)
    );

    int checks = 0;
    int errors = 0;

    // Pulse counters sampled away from the active edge
    int n_trig_a = 0, n_unk_a = 0, n_ferr_a = 0;
    int n_trig_b = 0, n_unk_b = 0;

    always @(negedge clk) begin
        if (trig_a) n_trig_a++;
        if (unk_a)  n_unk_a++;
        if (ferr_a) n_ferr_a++;
        if (trig_b) n_trig_b++;
        if (unk_b)  n_unk_b++;
    end

    typedef struct {
        logic [15:0] word;
        logic        en;
        logic        test;
        logic [31:0] cnt;
        int          dtrig;
        int          dunk;
        logic [15:0] err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_mclk(input bit b, input logic v);
        if (b) mclk_b = v;
        else   mclk_a = v;
    endtask

    // Send one word MSB first; MCLK is left high after the final edge.
    // Returns whether rx_valid appeared and on which negedge after that edge.
    task automatic xfer(input bit b, input logic [15:0] w, output bit got, output int lat);
        int beats;
        beats = b ? 4 : 16;
        for (int k = beats - 1; k >= 0; k--) begin
            @(negedge clk);
            set_mclk(b, 1'b0);
            if (b) mosi_b = w[k*4 +: 4];
            else   mosi_a = w[k];
            repeat (3) @(negedge clk);
            set_mclk(b, 1'b1);
            if (k > 0) repeat (3) @(negedge clk);
        end
        got = 1'b0;
        lat = 0;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if ((b ? vld_b : vld_a) === 1'b1) begin
                got = 1'b1;
                lat = t;
                break;
            end
        end
    endtask

    // Send a word and check the capture cycle, then the decoded outputs
    task automatic do_row(input bit b, input vec_t v, input logic pen);
        bit got;
        int lat, t0, u0;
        t0 = b ? n_trig_b : n_trig_a;
        u0 = b ? n_unk_b  : n_unk_a;
        xfer(b, v.word, got, lat);
        chk("rx_valid seen", 32'(got), 32'd1);
        if (got) begin
            chk("valid latency", lat, 4);
            chk("rx_data", b ? data_b : data_a, v.word);
            chk("en before decode", b ? en_b : en_a, pen);
        end
        @(negedge clk);
        chk("pmt_start_en", b ? en_b : en_a, v.en);
        chk("pmt_start_test_en", b ? test_b : test_a, v.test);
        chk("encode_cnt", b ? cnt_b : cnt_a, v.cnt);
        repeat (2) @(negedge clk);
        chk("trigger pulses", (b ? n_trig_b : n_trig_a) - t0, v.dtrig);
        chk("unknown pulses", (b ? n_unk_b : n_unk_a) - u0, v.dunk);
        chk("err_cnt", b ? err_b : err_a, v.err);
    endtask

    task automatic chk_zero(input bit b);
        chk("rst rx_valid", b ? vld_b : vld_a, 0);
        chk("rst rx_data", b ? data_b : data_a, 0);
        chk("rst trigger", b ? trig_b : trig_a, 0);
        chk("rst en", b ? en_b : en_a, 0);
        chk("rst test_en", b ? test_b : test_a, 0);
        chk("rst encode_cnt", b ? cnt_b : cnt_a, 0);
        chk("rst frame_err", b ? ferr_b : ferr_a, 0);
        chk("rst unknown", b ? unk_b : unk_a, 0);
        chk("rst err_cnt", b ? err_b : err_a, 0);
    endtask

    // Partial word on the single-lane link; MCLK left low afterwards
    task automatic edges_a(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            mclk_a = 1'b0;
            mosi_a = 1'(k);
            repeat (3) @(negedge clk);
            mclk_a = 1'b1;
            repeat (4) @(negedge clk);
        end
        @(negedge clk);
        mclk_a = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t tbl_a[12];
    vec_t tbl_b[3];
    vec_t v;
    logic pen;
    int   f0;

    initial begin
        tbl_a[0]  = '{16'h5A51, 1'b1, 1'b0, 32'd0, 0, 0, 16'd0};
        tbl_a[1]  = '{16'hECDE, 1'b1, 1'b0, 32'd1, 1, 0, 16'd0};
        tbl_a[2]  = '{16'hECDE, 1'b1, 1'b0, 32'd2, 1, 0, 16'd0};
        tbl_a[3]  = '{16'hECDE, 1'b1, 1'b0, 32'd3, 1, 0, 16'd0};
        tbl_a[4]  = '{16'h5A50, 1'b0, 1'b0, 32'd3, 0, 0, 16'd0};
        tbl_a[5]  = '{16'hECDE, 1'b0, 1'b0, 32'd3, 0, 0, 16'd0};
        tbl_a[6]  = '{16'h5A53, 1'b1, 1'b1, 32'd0, 0, 0, 16'd0};
        tbl_a[7]  = '{16'hECDE, 1'b1, 1'b1, 32'd1, 1, 0, 16'd0};
        tbl_a[8]  = '{16'h5A51, 1'b1, 1'b0, 32'd0, 0, 0, 16'd0};
        tbl_a[9]  = '{16'h5A50, 1'b0, 1'b0, 32'd0, 0, 0, 16'd0};
        tbl_a[10] = '{16'h5A50, 1'b0, 1'b0, 32'd0, 0, 0, 16'd0};
        tbl_a[11] = '{16'h1234, 1'b0, 1'b0, 32'd0, 0, 1, 16'd1};

        tbl_b[0]  = '{16'h5A53, 1'b1, 1'b1, 32'd0, 0, 0, 16'd0};
        tbl_b[1]  = '{16'hECDE, 1'b1, 1'b1, 32'd1, 1, 0, 16'd0};
        tbl_b[2]  = '{16'h5A51, 1'b1, 1'b0, 32'd0, 0, 0, 16'd0};

        rst_n  = 1'b0;
        mclk_a = 1'b0; mosi_a = '0;
        mclk_b = 1'b0; mosi_b = '0;

        // MCLK activity during reset must not disturb anything
        for (int k = 0; k < 6; k++) begin
            repeat (3) @(negedge clk);
            mclk_a = ~mclk_a; mclk_b = ~mclk_b;
            mosi_a = ~mosi_a; mosi_b = ~mosi_b;
        end
        mclk_a = 1'b0; mclk_b = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero(1'b0);
        chk_zero(1'b1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reset mid-word: the partial word must be forgotten
        edges_a(5);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero(1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        pen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            do_row(1'b0, tbl_a[i], pen);
            pen = tbl_a[i].en;
        end

        // Idle timeout mid-word
        f0 = n_ferr_a;
        edges_a(7);
        repeat (40) @(negedge clk);
        chk("frame_err before timeout", n_ferr_a - f0, 0);
        repeat (40) @(negedge clk);
        chk("frame_err after timeout", n_ferr_a - f0, 1);
        chk("err_cnt after frame_err", err_a, 16'd2);
        chk("no rx_valid on timeout", vld_a, 0);
        v = '{16'h5A51, 1'b1, 1'b0, 32'd0, 0, 0, 16'd2};
        do_row(1'b0, v, 1'b0);

        // Saturation of the error counter
        @(negedge clk);
        force dut_a.err_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut_a.err_cnt_q;
        @(negedge clk);
        chk("err_cnt preset", err_a, 16'hFFFF);
        v = '{16'h1234, 1'b1, 1'b0, 32'd0, 0, 1, 16'hFFFF};
        do_row(1'b0, v, 1'b1);

        // Four-lane link
        pen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_row(1'b1, tbl_b[i], pen);
            pen = tbl_b[i].en;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
